spi_ram_master_arb: RTL

//  Two-requester SPI master that shares one SPI link to the SPI-slave + RAM subsystem.

---
 rtl/spi_ram_master_arb.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/spi_ram_master_arb.sv
// Two-requester SPI master: round-robin arbitrates RAM read/write requests and
// serialises each into two 10-bit frames over one shared SS_n/MOSI/MISO link.
module spi_ram_master_arb #(
  parameter int IDLE_GAP   = 1,
  parameter int TURNAROUND = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_we,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_we,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT_A, S_GAP, S_SHIFT_B, S_TURN, S_RECV, S_DONE
  } state_t;

  state_t        state;
  logic          rr_favour;
  logic [3:0]    bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] turn_cnt;
  logic [9:0]    tx_sr;
  logic [6:0]    rx_sr;
  logic          cur_we;
  logic          cur_id;
  logic [7:0]    cur_wdata;

  logic       grant_any;
  logic       grant_id;
  logic       g_we;
  logic [7:0] g_addr;
  logic [7:0] g_wdata;
  logic [9:0] frame_a;
  logic [9:0] frame_b;

  // rr_favour only breaks ties; a lone requester always wins
  always_comb begin
    grant_any = (state == S_IDLE) && !rst && (req0_valid || req1_valid);
    if (req0_valid && req1_valid) grant_id = rr_favour;
    else                          grant_id = req1_valid;
  end

  assign req0_ready = grant_any && !grant_id;
  assign req1_ready = grant_any && grant_id;

  assign g_we    = grant_id ? req1_we    : req0_we;
  assign g_addr  = grant_id ? req1_addr  : req0_addr;
  assign g_wdata = grant_id ? req1_wdata : req0_wdata;

  assign frame_a = {~g_we, 1'b0, g_addr};
  assign frame_b = cur_we ? {2'b01, cur_wdata} : {2'b11, 8'h00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_rdata <= 8'h00;
      busy      <= 1'b0;
      rr_favour <= 1'b0;
      bit_cnt   <= 4'd0;
      gap_cnt   <= '0;
      turn_cnt  <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      cur_we    <= 1'b0;
      cur_id    <= 1'b0;
      cur_wdata <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            state     <= S_SHIFT_A;
            busy      <= 1'b1;
            SS_n      <= 1'b0;
            MOSI      <= frame_a[9];
            tx_sr     <= {frame_a[8:0], 1'b0};
            bit_cnt   <= 4'd9;
            cur_we    <= g_we;
            cur_id    <= grant_id;
            cur_wdata <= g_wdata;
            rr_favour <= ~grant_id;
          end
        end
        S_SHIFT_A: begin
          if (bit_cnt == 4'd0) begin
            state   <= S_GAP;
            SS_n    <= 1'b1;
            MOSI    <= 1'b0;
            gap_cnt <= GW'(IDLE_GAP - 1);
          end else begin
            bit_cnt <= bit_cnt - 4'd1;
            MOSI    <= tx_sr[9];
            tx_sr   <= {tx_sr[8:0], 1'b0};
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            state   <= S_SHIFT_B;
            SS_n    <= 1'b0;
            MOSI    <= frame_b[9];
            tx_sr   <= {frame_b[8:0], 1'b0};
            bit_cnt <= 4'd9;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        S_SHIFT_B: begin
          if (bit_cnt == 4'd0) begin
            MOSI <= 1'b0;
            if (cur_we) begin
              state     <= S_DONE;
              SS_n      <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_id    <= cur_id;
              rsp_rdata <= 8'h00;
            end else if (TURNAROUND > 0) begin
              state    <= S_TURN;
              turn_cnt <= TW'(TURNAROUND - 1);
            end else begin
              state   <= S_RECV;
              bit_cnt <= 4'd7;
            end
          end else begin
            bit_cnt <= bit_cnt - 4'd1;
            MOSI    <= tx_sr[9];
            tx_sr   <= {tx_sr[8:0], 1'b0};
          end
        end
        S_TURN: begin
          if (turn_cnt == '0) begin
            state   <= S_RECV;
            bit_cnt <= 4'd7;
          end else begin
            turn_cnt <= turn_cnt - TW'(1);
          end
        end
        S_RECV: begin
          // the eighth bit goes straight into rsp_rdata, so only seven are staged
          rx_sr <= {rx_sr[5:0], MISO};
          if (bit_cnt == 4'd0) begin
            state     <= S_DONE;
            SS_n      <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            rsp_rdata <= {rx_sr, MISO};
          end else begin
            bit_cnt <= bit_cnt - 4'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          SS_n  <= 1'b1;
          MOSI  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
